riscv_zero_fetch: RTL and testbench
===================================

Name: riscv_zero_fetch

Overview:
Instruction fetch stage feeding riscv_zero_decode. It holds the fetch PC and issues word reads to instruction memory over a req/ack interface, with at most one read outstanding. Returned words are buffered with their PC in a small FIFO and presented to decode as inst_data/pc_out. Redirects from execute (taken jump/branch) flush the FIFO and discard any in-flight response.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  single-cycle read request, address on imem_addr
imem_addr  output  64  read address = current fetch PC
imem_ack  input  1  read data valid; arrives >=1 cycle after imem_req
imem_rdata  input  32  instruction word, valid when imem_ack=1
redirect  input  1  taken jump/branch from execute
redirect_pc  input  64  redirect target
stall  input  1  decode not accepting this cycle
inst_valid  output  1  inst_data/pc_out hold a real instruction
inst_data  output  32  instruction to decode; 32'h00000013 (NOP) when inst_valid=0
pc_out  output  64  PC of inst_data; 0 when inst_valid=0

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, FIFO empty, state IDLE, imem_req=0, inst_valid=0, inst_data=32'h00000013, pc_out=0. Reset mid-operation abandons any outstanding read.
- State machine: IDLE (no read outstanding), WAIT (read outstanding, response kept), DROP (read outstanding, response discarded).
- Pop: inst_valid && !stall. FIFO head advances at the clock edge. Outputs are driven from registered FIFO head.
- Issue condition: no redirect, and either state IDLE with count<FIFO_DEPTH, or state WAIT with imem_ack and (count+1-pop)<FIFO_DEPTH. On issue, imem_req=1, imem_addr=fetch_pc, fetch_pc+=4 (64-bit wrap), and the state becomes/stays WAIT.
- WAIT && imem_ack && !redirect: push {fetch PC of that request, imem_rdata}. The state becomes IDLE unless a new read issues in the same cycle. A 1-cycle memory therefore sustains one instruction per cycle.
- Latency: req in cycle N, ack in N+1, inst_valid in N+2.
- redirect (highest priority, any state): fetch_pc=redirect_pc with bits[1:0] forced to 0. FIFO is flushed, so inst_valid=0 next cycle, and any same-cycle pop is void. No request issues that cycle.
  - IDLE: remains IDLE.
  - WAIT without ack: goes to DROP.
  - WAIT with ack: ack discarded, goes to IDLE.
  - DROP: remains DROP.
- DROP && imem_ack: response discarded, goes to IDLE, no push.
- imem_ack in IDLE (e.g. stale after reset): ignored.
- FIFO full (count=FIFO_DEPTH): no issue. A push while full cannot occur by construction; the bench asserts this.
- imem_addr is undefined-don't-care when imem_req=0; it is driven as fetch_pc.

Optional Feature:
FETCH_STALL_CNT_EN:
- Defined: adds output fetch_stall_cycles [31:0]. Increments each cycle with inst_valid && stall, saturates at 32'hFFFFFFFF, and asynchronous reset sets it to 0. Not cleared by redirect.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Test Plan:
1. Reset RESET_PC=0, 1-cycle memory returning rdata=addr, stall=0:
   - imem_addr 0,4,8,... on consecutive cycles.
   - inst_valid high from cycle 2 continuously, with pc_out/inst_data 0,4,8,...
2. stall=1 for 5 cycles mid-stream:
   - FIFO fills to 2 and imem_req drops low.
   - pc_out held.
   - After release, the sequence resumes with no skipped or duplicated PC.
3. Memory latency 3 cycles, redirect to 0x100 one cycle after req to 0x8:
   - The 0x8 response is dropped.
   - Next imem_addr=0x100.
   - First inst_valid has pc_out=0x100.
4. redirect with redirect_pc=0x102 coincident with imem_ack in WAIT:
   - The ack is dropped.
   - Next imem_addr=0x100.
   - inst_valid=0 the following cycle.
5. reset asserted while in WAIT, then a late imem_ack after release:
   - All outputs reach reset values immediately.
   - The late ack is ignored.
   - The first request is to RESET_PC.
6. With FETCH_STALL_CNT_EN, hold stall=1 for 7 cycles with valid output:
   - fetch_stall_cycles=7.
   - Counter holds while stall=0.

Source files
------------

// File: rtl/riscv_zero_fetch.sv
// Fetch stage: holds the fetch PC, issues single-outstanding imem reads and buffers words for decode.
// Optional macro FETCH_STALL_CNT_EN adds the fetch_stall_cycles counter output.
module riscv_zero_fetch #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
`ifdef FETCH_STALL_CNT_EN
   output logic [31:0] fetch_stall_cycles,
`endif
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [63:0] pc_out
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = CW + 1;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   state_t        state;
   logic [63:0]   fetch_pc;
   logic [63:0]   req_pc;
   fetch_entry_t  fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [OW-1:0] occ_after;
   logic          pop;
   logic          push;
   logic          issue;

   // Decode sees the registered FIFO head, or a NOP bubble when empty
   always_comb begin
      inst_valid = (count != '0);
      inst_data  = NOP;
      pc_out     = '0;
      if (count != '0) begin
         inst_data = fifo_mem[rd_ptr].inst;
         pc_out    = fifo_mem[rd_ptr].pc;
      end
   end

   // An ack in WAIT frees the port, so the next read may issue in the same cycle
   always_comb begin
      pop       = inst_valid && !stall && !redirect;
      push      = (state == WAIT) && imem_ack && !redirect;
      occ_after = OW'(count) + OW'(1) - OW'(pop);
      issue     = 1'b0;
      if (!reset && !redirect) begin
         if (state == IDLE && count < CW'(FIFO_DEPTH))
            issue = 1'b1;
         else if (push && occ_after < OW'(FIFO_DEPTH))
            issue = 1'b1;
      end
   end

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         case (state)
            IDLE: if (issue) state <= WAIT;
            WAIT: begin
               if (redirect)
                  state <= imem_ack ? IDLE : DROP;
               else if (imem_ack && !issue)
                  state <= IDLE;
            end
            // An ack here retires the abandoned read, even alongside a redirect
            DROP: if (imem_ack) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (redirect) begin
            fetch_pc <= redirect_pc & ~64'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 64'd4;
               req_pc   <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Payload storage needs no reset; count gates visibility
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{pc: req_pc, inst: imem_rdata};
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fetch_stall_cycles <= '0;
      else if (inst_valid && stall && fetch_stall_cycles != 32'hFFFFFFFF)
         fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// Bench for riscv_zero_fetch: latency-programmable memory model plus a PC-stream scoreboard.
module tb_riscv_zero_fetch;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        stall;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [63:0] pc_out;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] fetch_stall_cycles;
`endif

   always #5 clk = ~clk;

   riscv_zero_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .stall(stall),
`ifdef FETCH_STALL_CNT_EN
      .fetch_stall_cycles(fetch_stall_cycles),
`endif
      .inst_valid(inst_valid), .inst_data(inst_data), .pc_out(pc_out)
   );

   int tests = 0;
   int fails = 0;

   // memory model
   bit          mem_auto;
   bit          mem_busy;
   int          mem_cnt;
   logic [63:0] mem_addr;
   int          lat_min, lat_max;

   // scoreboard state
   logic [63:0] exp_fetch, exp_pc;
   int          inflight;
   bit          prev_redirect;
   int          pops;

   // observations of the last ticked cycle
   logic        obs_req, obs_ack, obs_valid;
   logic [63:0] obs_addr, obs_pc;
   logic [31:0] obs_data;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return 32'(a);
   endfunction

   task automatic sb_reset();
      exp_fetch     = RESET_PC;
      exp_pc        = RESET_PC;
      inflight      = 0;
      prev_redirect = 0;
      mem_busy      = 0;
      mem_cnt       = 0;
      imem_ack      = 1'b0;
   endtask

   task automatic do_reset(input int lmin, input int lmax);
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_rdata = '0; mem_auto = 1; lat_min = lmin; lat_max = lmax;
      sb_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One cycle from negedge to negedge: memory response, observation, scoreboard
   task automatic tick();
      if (mem_auto) begin
         imem_ack = 1'b0;
         if (mem_busy) begin
            if (mem_cnt > 0) mem_cnt--;
            if (mem_cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = word_of(mem_addr);
            end
         end
      end
      #1;
      obs_req = imem_req; obs_addr = imem_addr; obs_ack = imem_ack;
      obs_valid = inst_valid; obs_pc = pc_out; obs_data = inst_data;

      if (prev_redirect) begin
         tests++;
         if (obs_valid !== 1'b0) begin fails++; $display("FAIL valid_after_redirect: got %b want 0", obs_valid); end
      end
      if (obs_valid === 1'b1) begin
         tests++;
         if (obs_pc !== exp_pc) begin fails++; $display("FAIL pc_sequence: got %h want %h", obs_pc, exp_pc); end
         tests++;
         if (obs_data !== word_of(obs_pc)) begin fails++; $display("FAIL inst_data: got %h want %h", obs_data, word_of(obs_pc)); end
      end else begin
         tests++;
         if (obs_data !== NOP || obs_pc !== 64'h0) begin
            fails++; $display("FAIL bubble_outputs: got data %h pc %h want %h / 0", obs_data, obs_pc, NOP);
         end
      end
      if (obs_req === 1'b1) begin
         tests++;
         if (redirect) begin fails++; $display("FAIL req_during_redirect: got req=1 want 0"); end
         tests++;
         if (obs_addr !== exp_fetch) begin fails++; $display("FAIL imem_addr: got %h want %h", obs_addr, exp_fetch); end
         if (mem_auto) begin
            tests++;
            if (mem_busy && !obs_ack) begin fails++; $display("FAIL one_outstanding: got second req at %h want none", obs_addr); end
         end
      end

      if (redirect) begin
         exp_fetch = redirect_pc & ~64'h3;
         exp_pc    = exp_fetch;
         inflight  = 0;
      end else begin
         if (obs_req === 1'b1) begin exp_fetch += 64'd4; inflight++; end
         if (obs_valid === 1'b1 && !stall) begin exp_pc += 64'd4; inflight--; pops++; end
         tests++;
         if (inflight > DEPTH) begin fails++; $display("FAIL buffer_overflow: got %0d entries want <= %0d", inflight, DEPTH); end
      end
      prev_redirect = redirect;

      if (mem_auto) begin
         if (obs_ack) mem_busy = 0;
         if (obs_req === 1'b1) begin
            mem_busy = 1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
            mem_addr = obs_addr;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
      #1;
      tests++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
      tests++;
      if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      tests++;
      if (inst_data !== NOP) begin fails++; $display("FAIL reset_data: got %h want %h", inst_data, NOP); end
      tests++;
      if (pc_out !== 64'h0) begin fails++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
      tests++;
      if (imem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
`ifdef FETCH_STALL_CNT_EN
      tests++;
      if (fetch_stall_cycles !== 32'h0) begin fails++; $display("FAIL reset_stall_cnt: got %0d want 0", fetch_stall_cycles); end
`endif
      @(negedge clk);
   endtask

   task automatic test_stream();
      do_reset(1, 1);
      for (int i = 0; i < 12; i++) begin
         tick();
         tests++;
         if (obs_req !== 1'b1 || obs_addr !== 64'(4 * i)) begin
            fails++; $display("FAIL stream_req[%0d]: got req %b addr %h want 1 %h", i, obs_req, obs_addr, 64'(4 * i));
         end
         tests++;
         if (obs_valid !== (i >= 2)) begin fails++; $display("FAIL stream_valid[%0d]: got %b want %b", i, obs_valid, (i >= 2)); end
         if (i >= 2) begin
            tests++;
            if (obs_pc !== 64'(4 * (i - 2)) || obs_data !== 32'(4 * (i - 2))) begin
               fails++; $display("FAIL stream_out[%0d]: got %h/%h want %h", i, obs_pc, obs_data, 4 * (i - 2));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [63:0] held;
      do_reset(1, 1);
      for (int i = 0; i < 6; i++) tick();
      stall = 1'b1;
      tick();
      held = obs_pc;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         tests++;
         if (obs_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d]: got %b want 0", i, obs_req); end
         tests++;
         if (obs_valid !== 1'b1 || obs_pc !== held) begin
            fails++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, obs_valid, obs_pc, held);
         end
      end
      stall = 1'b0;
      tick();
      tick();
      tests++;
      if (obs_valid !== 1'b1 || obs_pc !== held + 64'd4) begin
         fails++; $display("FAIL stall_resume: got %b/%h want 1/%h", obs_valid, obs_pc, held + 64'd4);
      end
      for (int i = 0; i < 8; i++) tick();
   endtask

   task automatic test_redirect_drop();
      bit found;
      do_reset(3, 3);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (obs_req === 1'b1 && obs_addr === 64'h8) found = 1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL drop_setup: got no req to 8 want one within 40 cycles"); end
      redirect = 1'b1; redirect_pc = 64'h100;
      tick();
      redirect = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (obs_req === 1'b1) found = 1;
      end
      tests++;
      if (!found || obs_addr !== 64'h100) begin fails++; $display("FAIL drop_next_addr: got %h want 100", obs_addr); end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (obs_valid === 1'b1) found = 1;
      end
      tests++;
      if (!found || obs_pc !== 64'h100) begin fails++; $display("FAIL drop_first_valid: got %h want 100", obs_pc); end
   endtask

   task automatic test_redirect_ack();
      bit found;
      do_reset(2, 2);
      for (int i = 0; i < 3; i++) tick();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_busy && mem_cnt == 1) found = 1;
         else tick();
      end
      tests++;
      if (!found) begin fails++; $display("FAIL ack_setup: got no pending ack want one within 20 cycles"); end
      redirect = 1'b1; redirect_pc = 64'h102;
      tick();
      redirect = 1'b0;
      tests++;
      if (obs_ack !== 1'b1 || obs_req !== 1'b0) begin
         fails++; $display("FAIL ack_redirect_cycle: got ack %b req %b want 1 0", obs_ack, obs_req);
      end
      tick();
      tests++;
      if (obs_valid !== 1'b0) begin fails++; $display("FAIL ack_flush_valid: got %b want 0", obs_valid); end
      tests++;
      if (obs_req !== 1'b1 || obs_addr !== 64'h100) begin
         fails++; $display("FAIL ack_next_addr: got %b/%h want 1/100", obs_req, obs_addr);
      end
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_reset_wait();
      do_reset(1, 1);
      for (int i = 0; i < 4; i++) tick();
      mem_auto = 0;
      imem_ack = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      tests++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== NOP || pc_out !== 64'h0 || imem_addr !== RESET_PC) begin
         fails++; $display("FAIL async_reset: got req %b valid %b data %h pc %h addr %h want 0 0 %h 0 %h",
                           imem_req, inst_valid, inst_data, pc_out, imem_addr, NOP, RESET_PC);
      end
      @(negedge clk);
      reset = 1'b0;
      sb_reset();
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();
      tests++;
      if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
         fails++; $display("FAIL first_req_after_reset: got %b/%h want 1/%h", obs_req, obs_addr, RESET_PC);
      end
      imem_rdata = word_of(RESET_PC);
      tick();
      tests++;
      if (obs_valid !== 1'b0) begin fails++; $display("FAIL stale_ack_ignored: got valid %b want 0", obs_valid); end
      imem_ack = 1'b0;
      tick();
      tests++;
      if (obs_valid !== 1'b1 || obs_pc !== RESET_PC || obs_data !== word_of(RESET_PC)) begin
         fails++; $display("FAIL reset_first_inst: got %b/%h/%h want 1/%h/%h", obs_valid, obs_pc, obs_data, RESET_PC, word_of(RESET_PC));
      end
   endtask

   task automatic test_random();
      do_reset(1, 4);
      pops = 0;
      for (int i = 0; i < 3000; i++) begin
         stall    = ($urandom_range(3, 0) == 0);
         redirect = ($urandom_range(39, 0) == 0);
         if ($urandom_range(3, 0) == 0)
            redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
         else
            redirect_pc = {$urandom, $urandom};
         tick();
      end
      stall = 1'b0; redirect = 1'b0;
      tests++;
      if (pops < 300) begin fails++; $display("FAIL random_progress: got %0d pops want >= 300", pops); end
   endtask

`ifdef FETCH_STALL_CNT_EN
   task automatic test_stall_cnt();
      do_reset(1, 1);
      tests++;
      if (fetch_stall_cycles !== 32'd0) begin fails++; $display("FAIL stall_cnt_init: got %0d want 0", fetch_stall_cycles); end
      for (int i = 0; i < 3; i++) tick();
      stall = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      stall = 1'b0;
      tests++;
      if (fetch_stall_cycles !== 32'd7) begin fails++; $display("FAIL stall_cnt_seven: got %0d want 7", fetch_stall_cycles); end
      for (int i = 0; i < 5; i++) tick();
      tests++;
      if (fetch_stall_cycles !== 32'd7) begin fails++; $display("FAIL stall_cnt_hold: got %0d want 7", fetch_stall_cycles); end
   endtask
`endif

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0; mem_auto = 1; lat_min = 1; lat_max = 1;
      sb_reset();
      pops = 0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_ack();
      test_reset_wait();
      test_random();
`ifdef FETCH_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
